// File: rtl/dec_select_sequencer_if.sv
// Select/enable bundle between the scan sequencer and whatever drives its controls.
// The master drives the controls and the slave (the sequencer) drives the decoder lines and status.
interface dec_select_sequencer_if #(
   parameter int DWELL_W = 8
);
   logic               start;
   logic               stop;
   logic               dir;
   logic               single;
   logic [DWELL_W-1:0] dwell;
   logic               x;
   logic               y;
   logic               z;
   logic               enable;
   logic               busy;
   logic               wrap;
   logic               done;

   modport master (
      output start, stop, dir, single, dwell,
      input  x, y, z, enable, busy, wrap, done
   );

   modport slave (
      input  start, stop, dir, single, dwell,
      output x, y, z, enable, busy, wrap, done
   );
endinterface

// File: rtl/dec_select_sequencer.sv
// Drives the 3:8 decoder select lines, stepping through all eight outputs.
// Each output is held for a programmable dwell, and the scan can run up or down, once or continuously.
module dec_select_sequencer #(
   parameter int DWELL_W = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   dec_select_sequencer_if.slave  bus
);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   localparam logic [DWELL_W-1:0] CNT_ONE = DWELL_W'(1);

   state_t             state,    state_n;
   logic [2:0]         index,    index_n;
   logic [DWELL_W-1:0] cnt,      cnt_n;
   logic [DWELL_W-1:0] dwell_l,  dwell_n;
   logic               dir_l,    dir_n;
   logic               single_l, single_n;
   logic               wrap_q,   wrap_n;
   logic               done_q,   done_n;
   logic               last_index;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         index    <= 3'd0;
         cnt      <= '0;
         dwell_l  <= '0;
         dir_l    <= 1'b0;
         single_l <= 1'b0;
         wrap_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state    <= state_n;
         index    <= index_n;
         cnt      <= cnt_n;
         dwell_l  <= dwell_n;
         dir_l    <= dir_n;
         single_l <= single_n;
         wrap_q   <= wrap_n;
         done_q   <= done_n;
      end
   end

   // The index is forced to 0 whenever the scan ends, so the select lines can come straight off it.
   always_comb begin
      state_n    = state;
      index_n    = index;
      cnt_n      = cnt;
      dwell_n    = dwell_l;
      dir_n      = dir_l;
      single_n   = single_l;
      wrap_n     = 1'b0;
      done_n     = 1'b0;
      last_index = dir_l ? (index == 3'd0) : (index == 3'd7);

      case (state)
         IDLE: begin
            if (bus.start && !bus.stop) begin
               state_n  = RUN;
               dir_n    = bus.dir;
               single_n = bus.single;
               dwell_n  = bus.dwell;
               index_n  = bus.dir ? 3'd7 : 3'd0;
               cnt_n    = '0;
            end
         end
         RUN: begin
            if (bus.stop) begin
               state_n = IDLE;
               index_n = 3'd0;
               cnt_n   = '0;
               done_n  = 1'b1;
            end else if (cnt != dwell_l) begin
               cnt_n = cnt + CNT_ONE;
            end else begin
               cnt_n = '0;
               if (!last_index) begin
                  index_n = dir_l ? (index - 3'd1) : (index + 3'd1);
               end else if (!single_l) begin
                  index_n = dir_l ? 3'd7 : 3'd0;
                  wrap_n  = 1'b1;
               end else begin
                  state_n = IDLE;
                  index_n = 3'd0;
                  done_n  = 1'b1;
               end
            end
         end
         default: begin
            state_n = IDLE;
            index_n = 3'd0;
            cnt_n   = '0;
         end
      endcase
   end

   assign bus.x      = index[2];
   assign bus.y      = index[1];
   assign bus.z      = index[0];
   assign bus.enable = (state == RUN);
   assign bus.busy   = (state == RUN);
   assign bus.wrap   = wrap_q;
   assign bus.done   = done_q;

endmodule
